// File: rtl/window3x3_gen_pkg.sv
// Shared types and slot layout for the 3x3 window
// stream consumed by the RGB444 filter stage.
package window_pkg;

  localparam int PIX_W = 12;
  localparam int WIN_W = 9 * PIX_W;

  localparam int CENTER    = 96;
  localparam int LEFT      = 84;
  localparam int RIGHT     = 72;
  localparam int UP        = 60;
  localparam int DOWN      = 48;
  localparam int UPLEFT    = 36;
  localparam int UPRIGHT   = 24;
  localparam int DOWNLEFT  = 12;
  localparam int DOWNRIGHT = 0;

  typedef enum logic [0:0] {
    WAIT_SOF = 1'b0,
    RUN      = 1'b1
  } state_e;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [WIN_W-1:0] win_t;

  function automatic win_t pack_win(
    input pix_t ce,
    input pix_t lf,
    input pix_t rt,
    input pix_t up,
    input pix_t dn,
    input pix_t ul,
    input pix_t ur,
    input pix_t dl,
    input pix_t dr
  );
    win_t w;
    w = '0;
    w[CENTER    +: PIX_W] = ce;
    w[LEFT      +: PIX_W] = lf;
    w[RIGHT     +: PIX_W] = rt;
    w[UP        +: PIX_W] = up;
    w[DOWN      +: PIX_W] = dn;
    w[UPLEFT    +: PIX_W] = ul;
    w[UPRIGHT   +: PIX_W] = ur;
    w[DOWNLEFT  +: PIX_W] = dl;
    w[DOWNRIGHT +: PIX_W] = dr;
    return w;
  endfunction

endpackage

// File: rtl/window3x3_gen_if.sv
// Pixel-in / window-out bundle of window3x3_gen.
// master drives pixels, slave is the generator.
interface window3x3_gen_if ();
  import window_pkg::*;

  pix_t pix_in;
  logic pix_valid;
  logic pix_sof;
  win_t color_data;
  logic win_valid;
  logic win_last;

  modport master (
    output pix_in,
    output pix_valid,
    output pix_sof,
    input  color_data,
    input  win_valid,
    input  win_last
  );

  modport slave (
    input  pix_in,
    input  pix_valid,
    input  pix_sof,
    output color_data,
    output win_valid,
    output win_last
  );

endinterface

// File: rtl/window3x3_gen_line_buffer.sv
// One image row of pixels: simple dual-port RAM,
// registered read, old data returned on same-edge write.
module line_buffer
  import window_pkg::*;
#(
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  pix_t          wdata_i,
  output pix_t          rdata_o
);

  pix_t mem_q [DEPTH];
  pix_t rdata_q;

  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two row
// buffers plus a shifting 3x3 register window.
module window3x3_gen
  import window_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic              clk,
  input  logic              reset,
  window3x3_gen_if.slave    bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] C_TWO  = CW'(2);
  localparam logic [RW-1:0] R_TWO  = RW'(2);

  localparam logic [0:0] S_WAIT = WAIT_SOF;
  localparam logic [0:0] S_RUN  = RUN;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d, cur_c;
  logic [RW-1:0] row_q, row_d, cur_r;
  logic          acc, emit, fend;

  always_comb begin
    acc   = bus.pix_valid &
            ((state_q == S_RUN) | bus.pix_sof);
    cur_c = bus.pix_sof ? '0 : col_q;
    cur_r = bus.pix_sof ? '0 : row_q;
    fend  = (cur_r == R_LAST) && (cur_c == C_LAST);
    emit  = acc && (cur_r >= R_TWO) &&
            (cur_c >= C_TWO);
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (acc) begin
      if (fend) begin
        state_d = S_WAIT;
        col_d   = '0;
        row_d   = '0;
      end else begin
        state_d = S_RUN;
        if (cur_c == C_LAST) begin
          col_d = '0;
          row_d = cur_r + 1'b1;
        end else begin
          col_d = cur_c + 1'b1;
          row_d = cur_r;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  logic          s1_v_q, s1_emit_q, s1_last_q;
  pix_t          s1_px_q;
  logic [CW-1:0] s1_c_q;
  pix_t          a_rd, b_rd;

  // B is fed from A's read port one cycle later,
  // so row r-1 ages into row r-2 without a bypass.
  line_buffer #(.DEPTH(IMG_W)) u_buf_a (
    .clk     (clk),
    .re_i    (acc),
    .raddr_i (cur_c),
    .we_i    (acc),
    .waddr_i (cur_c),
    .wdata_i (bus.pix_in),
    .rdata_o (a_rd)
  );

  line_buffer #(.DEPTH(IMG_W)) u_buf_b (
    .clk     (clk),
    .re_i    (acc),
    .raddr_i (cur_c),
    .we_i    (s1_v_q),
    .waddr_i (s1_c_q),
    .wdata_i (a_rd),
    .rdata_o (b_rd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q    <= 1'b0;
      s1_emit_q <= 1'b0;
      s1_last_q <= 1'b0;
      s1_px_q   <= '0;
      s1_c_q    <= '0;
    end else begin
      s1_v_q    <= acc;
      s1_emit_q <= emit;
      s1_last_q <= fend;
      if (acc) begin
        s1_px_q <= bus.pix_in;
        s1_c_q  <= cur_c;
      end
    end
  end

  pix_t top_q [3];
  pix_t mid_q [3];
  pix_t bot_q [3];
  logic s2_emit_q, s2_last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        top_q[i] <= '0;
        mid_q[i] <= '0;
        bot_q[i] <= '0;
      end
      s2_emit_q <= 1'b0;
      s2_last_q <= 1'b0;
    end else begin
      s2_emit_q <= s1_v_q & s1_emit_q;
      s2_last_q <= s1_last_q;
      if (s1_v_q) begin
        top_q[0] <= top_q[1];
        top_q[1] <= top_q[2];
        top_q[2] <= b_rd;
        mid_q[0] <= mid_q[1];
        mid_q[1] <= mid_q[2];
        mid_q[2] <= a_rd;
        bot_q[0] <= bot_q[1];
        bot_q[1] <= bot_q[2];
        bot_q[2] <= s1_px_q;
      end
    end
  end

  win_t color_q;
  logic valid_q, last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= s2_emit_q;
      last_q  <= s2_emit_q & s2_last_q;
      if (s2_emit_q) begin
        color_q <= pack_win(
          mid_q[1], mid_q[0], mid_q[2],
          top_q[1], bot_q[1],
          top_q[0], top_q[2],
          bot_q[0], bot_q[2]);
      end
    end
  end

  assign bus.color_data = color_q;
  assign bus.win_valid  = valid_q;
  assign bus.win_last   = last_q;

endmodule

// File: doc/window3x3_gen.md
# window3x3_gen

Streaming 3x3 neighbourhood generator feeding the RGB444 pixel filter stage. Accepts a raster-ordered pixel stream, buffers two previous image rows and emits, for every interior pixel, a packed 108-bit window of nine 12-bit RGB444 pixels in the slot order the filter consumes. Sits between the camera/frame reader and the filter, one window per accepted interior pixel, no backpressure.

## Interface
- `IMG_W`, 640, pixels per row (>= 3)
- `IMG_H`, 480, rows per frame (>= 3)
- `PIX_W`, 12, bits per pixel (RGB444, R in [11:8], G in [7:4], B in [3:0])

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high
- `pix_in`  in  PIX_W  input pixel
- `pix_valid`  in  1  pixel qualifier; one pixel accepted per cycle when high
- `pix_sof`  in  1  first pixel of frame; meaningful only with `pix_valid`
- `color_data`  out  9*PIX_W  packed window
- `win_valid`  out  1  `color_data` valid, single-cycle pulse
- `win_last`  out  1  last window of frame, coincident with `win_valid`

## Operation
- States: WAIT_SOF, RUN. Reset → WAIT_SOF.
- WAIT_SOF: pixels without `pix_sof` are dropped. `pix_valid & pix_sof` → accept as (r=0,c=0), go RUN.
- RUN: each accepted pixel advances c; at c=IMG_W-1, c←0, r++. Accepting (IMG_H-1, IMG_W-1) → WAIT_SOF.
- `pix_valid & pix_sof` in RUN: resync; pixel taken as (0,0), counters restart, no window emitted for it.
- Line buffers: buffer A holds row r-1, buffer B row r-2, both addressed by c. On accept at c: read A[c], B[c]; write A[c]←pixel, B[c]←old A[c] (read-before-write).
- 3x3 register window shifts one column per accepted pixel: new column = {B[c], A[c], pixel}.
- Window for accepted pixel (r,c) is centred at (r-1,c-1). Emitted only when r>=2 and c>=2: (IMG_H-2)*(IMG_W-2) windows per frame. Columns 0,1 of each row contain stale previous-row data and are never emitted.
- Slot packing of `color_data`: [107:96] centre (r-1,c-1); [95:84] left (r-1,c-2); [83:72] right (r-1,c); [71:60] up (r-2,c-1); [59:48] down (r,c-1); [47:36] upleft (r-2,c-2); [35:24] upright (r-2,c); [23:12] downleft (r,c-2); [11:0] downright (r,c).
- `win_last` high with the window for accepted pixel (IMG_H-1, IMG_W-1).
- Pixel values pass unmodified; no arithmetic on pixel data.

## Timing
- Latency: pixel accepted at cycle t → its window on `color_data`/`win_valid` at cycle t+2. Fixed, independent of gaps.
- `pix_valid` low: no shift, no counter change, no window; pipeline holds. Bubbles propagate as `win_valid` low.
- `color_data` holds last window when `win_valid` low.
- Reset: `color_data`=0, `win_valid`=0, `win_last`=0, counters 0, state WAIT_SOF; immediate (asynchronous). In-flight windows discarded. Line-buffer RAM not cleared (overwritten by rows 0,1 before use).
- Resync via `pix_sof`: windows already in the 2-stage pipeline still emerge; none after.
- Back-to-back frames: `pix_sof` on cycle following the last pixel accepted normally.

## Structure
- Package `window_pkg`: `PIX_W`, `WIN_W`=9*PIX_W, slot LSB constants (CENTER=96, LEFT=84, RIGHT=72, UP=60, DOWN=48, UPLEFT=36, UPRIGHT=24, DOWNLEFT=12, DOWNRIGHT=0), state enum. Shared with the filter stage.
- Sub-module `line_buffer`: simple dual-port RAM, depth IMG_W, width PIX_W, 1-cycle registered read, read-before-write. Two instances (A, B).

## Test plan
All with IMG_W=4, IMG_H=4, pixel value = r*16+c.
- Continuous 4x4 frame with `pix_sof` on first pixel → exactly 4 windows; first appears 2 cycles after pixel (2,2), `color_data`=108'h011_010_012_001_021_000_002_020_022; 4th has `win_last`=1, centre 0x022.
- Same frame with `pix_valid` low every other cycle → same 4 windows, same values, each 2 cycles after its triggering pixel.
- 16 pixels without `pix_sof` after reset → no `win_valid`; then proper frame → normal 4 windows.
- `pix_sof` reasserted at pixel (1,2) of a frame, then full frame → only windows from new frame, values as scenario 1.
- `reset` asserted at pixel (2,3) → outputs 0 at once, no further windows; next frame correct.
- Pixel (1,1)=0xFFF, others 0 → window with centre 0xFFF at [107:96] then 0xFFF moving through left/up-left slots in subsequent windows.
